// File: rtl/timer_pkg.sv
// Shared constants and types for the 8-bit timer APB responder.
// Register addresses, TCR/TSR bit positions and the APB state encoding live here.
package timer_pkg;

   localparam logic [7:0] ADDR_TDR  = 8'h00;
   localparam logic [7:0] ADDR_TCR  = 8'h01;
   localparam logic [7:0] ADDR_TSR  = 8'h02;
   localparam logic [7:0] ADDR_TCNT = 8'h03;

   localparam int unsigned TCR_LOAD   = 7;
   localparam int unsigned TCR_DOWN   = 5;
   localparam int unsigned TCR_EN     = 4;
   localparam int unsigned TCR_CKS_HI = 1;
   localparam int unsigned TCR_CKS_LO = 0;

   localparam int unsigned TSR_OVF = 0;
   localparam int unsigned TSR_UDF = 1;

   // Bits 6 and 3:2 of TCR are reserved and never stored.
   localparam logic [7:0] TCR_WMASK = 8'hB3;

   typedef enum logic {IDLE, ACCESS} apb_state_e;

endpackage

// File: rtl/timer_tsr_flag.sv
// One sticky status flag: a hardware set outranks a software clear in the same cycle.
module timer_tsr_flag (
   input  logic pclk,
   input  logic preset,
   input  logic set_i,
   input  logic clr_i,
   output logic flag_o
);

   logic flag_q;

   always_ff @(posedge pclk) begin
      if (preset) begin
         flag_q <= 1'b0;
      end else if (set_i) begin
         flag_q <= 1'b1;
      end else if (clr_i) begin
         flag_q <= 1'b0;
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/timer_apb_slave.sv
// APB3 responder holding TDR/TCR/TSR and a read-only TCNT view for the 8-bit timer.
// Define TIMER_APB_PSLVERR_EN to answer unmapped accesses and TCNT writes with pslverr.
module timer_apb_slave
   import timer_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [7:0]        pwdata,
   output logic [7:0]        prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [7:0]        tdr_o,
   output logic [7:0]        tcr_o,
   input  logic [7:0]        tcnt_i,
   input  logic              ovf_set_i,
   input  logic              udf_set_i
);

   apb_state_e state_q;
   logic [2:0] wcnt_q;
   logic [7:0] tdr_q;
   logic [7:0] tcr_q;
   logic       ovf_q;
   logic       udf_q;

   logic       hit_tdr, hit_tcr, hit_tsr, hit_tcnt;
   logic       xfer_err;
   logic       complete;
   logic       wr_en;
   logic [7:0] rd_val;

   assign hit_tdr  = (paddr == ADDR_W'(ADDR_TDR));
   assign hit_tcr  = (paddr == ADDR_W'(ADDR_TCR));
   assign hit_tsr  = (paddr == ADDR_W'(ADDR_TSR));
   assign hit_tcnt = (paddr == ADDR_W'(ADDR_TCNT));

`ifdef TIMER_APB_PSLVERR_EN
   assign xfer_err = !(hit_tdr || hit_tcr || hit_tsr || hit_tcnt) || (pwrite && hit_tcnt);
`else
   assign xfer_err = 1'b0;
`endif

   assign pready   = (state_q == ACCESS) && (wcnt_q == 3'(WAIT_STATES));
   assign pslverr  = pready && xfer_err;
   assign complete = pready && psel && penable;
   // TCNT and unmapped addresses have no write decode, so those writes drop naturally.
   assign wr_en    = complete && pwrite && !xfer_err;

   always_comb begin
      rd_val = 8'h00;
      if (hit_tdr) begin
         rd_val = tdr_q;
      end else if (hit_tcr) begin
         rd_val = tcr_q;
      end else if (hit_tsr) begin
         rd_val = {6'b0, udf_q, ovf_q};
      end else if (hit_tcnt) begin
         rd_val = tcnt_i;
      end
   end

   assign prdata = (pready && !xfer_err) ? rd_val : 8'h00;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         wcnt_q  <= 3'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (psel && !penable) begin
                  state_q <= ACCESS;
                  wcnt_q  <= 3'd0;
               end
            end
            ACCESS: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else if (!pready) begin
                  wcnt_q <= wcnt_q + 3'd1;
               end else if (penable) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         tdr_q <= 8'h00;
         tcr_q <= 8'h00;
      end else if (wr_en) begin
         if (hit_tdr) tdr_q <= pwdata;
         if (hit_tcr) tcr_q <= pwdata & TCR_WMASK;
      end
   end

   timer_tsr_flag u_ovf (
      .pclk   (pclk),
      .preset (preset),
      .set_i  (ovf_set_i),
      .clr_i  (wr_en && hit_tsr && !pwdata[TSR_OVF]),
      .flag_o (ovf_q)
   );

   timer_tsr_flag u_udf (
      .pclk   (pclk),
      .preset (preset),
      .set_i  (udf_set_i),
      .clr_i  (wr_en && hit_tsr && !pwdata[TSR_UDF]),
      .flag_o (udf_q)
   );

   assign tdr_o = tdr_q;
   assign tcr_o = tcr_q;

endmodule

// File: tb/tb_timer_apb_slave.sv
// Self-checking bench for timer_apb_slave: directed vector table, corner sequences, random traffic.
module tb_timer_apb_slave;

   localparam int unsigned WS = 2;

   logic       pclk = 1'b0;
   logic       preset, psel, penable, pwrite;
   logic [7:0] paddr, pwdata, prdata, tdr_o, tcr_o, tcnt_i;
   logic       pready, pslverr, ovf_set_i, udf_set_i;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_tdr, m_tcr;
   logic       m_ovf, m_udf;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [1:0] evt;   // {udf, ovf} pulsed in the completing cycle
      logic [7:0] tcnt;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   timer_apb_slave #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
      .pclk      (pclk),
      .preset    (preset),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .tdr_o     (tdr_o),
      .tcr_o     (tcr_o),
      .tcnt_i    (tcnt_i),
      .ovf_set_i (ovf_set_i),
      .udf_set_i (udf_set_i)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit err_rule(input bit wr, input logic [7:0] a);
`ifdef TIMER_APB_PSLVERR_EN
      return (a > 8'h03) || (wr && a == 8'h03);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] a, input logic [7:0] tcnt);
      if (err_rule(1'b0, a)) return 8'h00;
      case (a)
         8'h00:   return m_tdr;
         8'h01:   return m_tcr;
         8'h02:   return {6'b0, m_udf, m_ovf};
         8'h03:   return tcnt;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_commit(input bit wr, input logic [7:0] a, input logic [7:0] d,
                               input logic [1:0] evt);
      if (wr && !err_rule(wr, a)) begin
         if (a == 8'h00) m_tdr = d;
         if (a == 8'h01) m_tcr = d & 8'hB3;
         if (a == 8'h02) begin
            if (!d[0]) m_ovf = 1'b0;
            if (!d[1]) m_udf = 1'b0;
         end
      end
      if (evt[0]) m_ovf = 1'b1;
      if (evt[1]) m_udf = 1'b1;
   endtask

   function automatic vec_t mkv(input bit wr, input logic [7:0] a, input logic [7:0] d,
                                input logic [1:0] evt, input logic [7:0] tcnt,
                                input logic [7:0] exp_rd);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.evt = evt; v.tcnt = tcnt; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic apb(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [1:0] evt, output logic [7:0] rd, output logic err);
      int n;
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(negedge pclk);
      penable = 1'b1;
      #1;
      n = 1;
      while (!pready && n < 16) begin
         @(negedge pclk);
         #1;
         n++;
      end
      chk("latency", 8'(n), 8'(WS + 1));
      rd  = prdata;
      err = pslverr;
      {udf_set_i, ovf_set_i} = evt;
      @(posedge pclk);
      #1;
      {udf_set_i, ovf_set_i} = 2'b00;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic run_xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [1:0] evt, input logic [7:0] exp_rd);
      logic [7:0] rd;
      logic       err;
      apb(wr, a, d, evt, rd, err);
      chk("pslverr", {7'b0, err}, {7'b0, err_rule(wr, a)});
      if (!wr) chk("prdata", rd, exp_rd);
      else if (err_rule(wr, a)) chk("prdata_err", rd, 8'h00);
      model_commit(wr, a, d, evt);
      chk("tdr_o", tdr_o, m_tdr);
      chk("tcr_o", tcr_o, m_tcr);
   endtask

   initial begin
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 8'h00; tcnt_i = 8'h00; ovf_set_i = 1'b0; udf_set_i = 1'b0;
      m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      chk("rst_pready", {7'b0, pready}, 8'h00);
      chk("rst_pslverr", {7'b0, pslverr}, 8'h00);
      chk("rst_prdata", prdata, 8'h00);
      chk("rst_tdr", tdr_o, 8'h00);
      chk("rst_tcr", tcr_o, 8'h00);
      @(negedge pclk);
      preset = 1'b0;

      vecs.push_back(mkv(1, 8'h00, 8'h63, 2'b00, 8'h00, 8'h00));
      vecs.push_back(mkv(0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h63));
      vecs.push_back(mkv(1, 8'h01, 8'hFF, 2'b00, 8'h00, 8'h00));
      vecs.push_back(mkv(0, 8'h01, 8'h00, 2'b00, 8'h00, 8'hB3));
      vecs.push_back(mkv(1, 8'h01, 8'h80, 2'b00, 8'h00, 8'h00));
      vecs.push_back(mkv(1, 8'h01, 8'h30, 2'b00, 8'h00, 8'h00));
      vecs.push_back(mkv(0, 8'h03, 8'h00, 2'b00, 8'h5A, 8'h5A));
      vecs.push_back(mkv(0, 8'h00, 8'h00, 2'b10, 8'h5A, 8'h63));
      vecs.push_back(mkv(0, 8'h02, 8'h00, 2'b00, 8'h5A, 8'h02));
      vecs.push_back(mkv(1, 8'h02, 8'h00, 2'b00, 8'h5A, 8'h00));
      vecs.push_back(mkv(0, 8'h02, 8'h00, 2'b00, 8'h5A, 8'h00));
      vecs.push_back(mkv(1, 8'h00, 8'h11, 2'b10, 8'h5A, 8'h00));
      vecs.push_back(mkv(1, 8'h02, 8'hFF, 2'b00, 8'h5A, 8'h00));
      vecs.push_back(mkv(0, 8'h02, 8'h00, 2'b00, 8'h5A, 8'h02));
      vecs.push_back(mkv(1, 8'h02, 8'h00, 2'b10, 8'h5A, 8'h00));
      vecs.push_back(mkv(0, 8'h02, 8'h00, 2'b00, 8'h5A, 8'h02));
      vecs.push_back(mkv(1, 8'h00, 8'h22, 2'b01, 8'h5A, 8'h00));
      vecs.push_back(mkv(0, 8'h02, 8'h00, 2'b00, 8'h5A, 8'h03));
      vecs.push_back(mkv(1, 8'h05, 8'hAA, 2'b00, 8'h5A, 8'h00));
      vecs.push_back(mkv(1, 8'h03, 8'h77, 2'b00, 8'h5A, 8'h00));
      vecs.push_back(mkv(0, 8'h00, 8'h00, 2'b00, 8'h5A, 8'h22));
      vecs.push_back(mkv(0, 8'h01, 8'h00, 2'b00, 8'h5A, 8'h30));
      vecs.push_back(mkv(0, 8'h07, 8'h00, 2'b00, 8'h5A, 8'h00));
      vecs.push_back(mkv(0, 8'h03, 8'h00, 2'b00, 8'hC3, 8'hC3));

      foreach (vecs[i]) begin
         tcnt_i = vecs[i].tcnt;
         run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].evt, vecs[i].exp_rd);
      end

      // Abort: psel drops mid-access, the write must not land.
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h99;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      #1;
      chk("abort_pready", {7'b0, pready}, 8'h00);
      run_xfer(1'b0, 8'h00, 8'h00, 2'b00, m_tdr);

      // penable without a setup phase is ignored.
      @(negedge pclk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
      repeat (4) @(negedge pclk);
      #1;
      chk("nosetup_pready", {7'b0, pready}, 8'h00);
      psel = 1'b0; penable = 1'b0;

      // Reset during the wait phase of a write.
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h44;
      @(negedge pclk);
      penable = 1'b1;
      #1;
      preset = 1'b1;
      @(posedge pclk);
      #1;
      chk("midrst_pready", {7'b0, pready}, 8'h00);
      chk("midrst_tdr", tdr_o, 8'h00);
      chk("midrst_tcr", tcr_o, 8'h00);
      chk("midrst_prdata", prdata, 8'h00);
      @(negedge pclk);
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
      run_xfer(1'b0, 8'h02, 8'h00, 2'b00, 8'h00);
      run_xfer(1'b0, 8'h00, 8'h00, 2'b00, 8'h00);

      // Random traffic against the reference model.
      for (int i = 0; i < 80; i++) begin
         bit         wr;
         logic [7:0] a, d, exp;
         logic [1:0] evt;
         wr     = 1'($urandom_range(0, 1));
         a      = 8'($urandom_range(0, 7));
         d      = 8'($urandom);
         evt    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         tcnt_i = 8'($urandom);
         exp    = model_read(a, tcnt_i);
         run_xfer(wr, a, d, evt, exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
